// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared types and constants for the square-root sequencer
package sqrt_pkg;

    // Default radicand width used when the sequencer is not parameterised
    localparam int DEFAULT_BITS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } sqrt_state_t;

    // Width of the iteration index for a given radicand width (EntradaBits/2 iterations)
    function automatic int iter_width(input int bits);
        return $clog2(bits / 2);
    endfunction

endpackage

// File: rtl/sqrt_iter_counter.sv
// rtl/sqrt_iter_counter.sv - loadable iteration down-counter with terminal-count flag
module sqrt_iter_counter #(
    parameter int            W        = 3,
    parameter logic [W-1:0]  LOAD_VAL = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         enable,
    output logic [W-1:0] iter_o,
    output logic         tc
);

    // Load the start index, then count down while enabled; parks at zero instead of wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_o <= '0;
        end else if (load) begin
            iter_o <= LOAD_VAL;
        end else if (enable && (iter_o != '0)) begin
            iter_o <= iter_o - 1'b1;
        end
    end

    assign tc = (iter_o == '0);

endmodule

// File: rtl/sqrt_sequencer.sv
// rtl/sqrt_sequencer.sv - control FSM for the iterative square-root datapath (optional SQRT_ABORT_EN adds abort input)
module sqrt_sequencer
    import sqrt_pkg::*;
#(
    parameter int EntradaBits = DEFAULT_BITS,
    localparam int ITER_W     = iter_width(EntradaBits)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EntradaBits-1:0] operand,
    input  logic [EntradaBits-1:0] root_i,
`ifdef SQRT_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   load_o,
    output logic [EntradaBits-1:0] d_o,
    output logic                   step_en_o,
    output logic [ITER_W-1:0]      iter_o,
    output logic                   busy,
    output logic                   done,
    output logic [EntradaBits-1:0] Raiz
);

    localparam int                N    = EntradaBits / 2;
    localparam logic [ITER_W-1:0] LAST = ITER_W'(N - 1);

    sqrt_state_t state;
    logic        tc;
    logic        abort_hit;
    logic        unused_root_hi;

`ifdef SQRT_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // Only the low half of the datapath root carries the result
    assign unused_root_hi = ^root_i[EntradaBits-1:N];

    sqrt_iter_counter #(
        .W        (ITER_W),
        .LOAD_VAL (LAST)
    ) u_iter_counter (
        .clk    (clk),
        .reset  (reset),
        .load   ((state == IDLE) && start),
        .enable (state == ITER),
        .iter_o (iter_o),
        .tc     (tc)
    );

    // Sequencing FSM; every strobe is registered alongside the state it belongs to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            load_o    <= 1'b0;
            step_en_o <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            d_o       <= '0;
            Raiz      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        d_o    <= operand;
                        load_o <= 1'b1;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    load_o <= 1'b0;
                    if (abort_hit) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        step_en_o <= 1'b1;
                        state     <= ITER;
                    end
                end
                ITER: begin
                    if (abort_hit) begin
                        step_en_o <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (tc) begin
                        // root_i already reflects the final step on this edge, so Raiz is valid with done
                        step_en_o <= 1'b0;
                        done      <= 1'b1;
                        Raiz      <= {{(EntradaBits - N){1'b0}}, root_i[N-1:0]};
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    load_o    <= 1'b0;
                    step_en_o <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_sequencer.sv
// tb/tb_sqrt_sequencer.sv - self-checking bench for sqrt_sequencer with behavioural model
module tb_sqrt_sequencer;

    localparam int EB = 16;
    localparam int N  = EB / 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [EB-1:0] operand;
    logic [EB-1:0] root_i;
    logic          load_o;
    logic [EB-1:0] d_o;
    logic          step_en_o;
    logic [2:0]    iter_o;
    logic          busy;
    logic          done;
    logic [EB-1:0] Raiz;
`ifdef SQRT_ABORT_EN
    logic          abort = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sqrt_sequencer #(.EntradaBits(EB)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .operand   (operand),
        .root_i    (root_i),
`ifdef SQRT_ABORT_EN
        .abort     (abort),
`endif
        .load_o    (load_o),
        .d_o       (d_o),
        .step_en_o (step_en_o),
        .iter_o    (iter_o),
        .busy      (busy),
        .done      (done),
        .Raiz      (Raiz)
    );

    always #5 clk = ~clk;

    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Stand-in datapath: its root is only correct once all N steps have been applied
    int            dp_steps;
    logic [EB-1:0] dp_d;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_steps <= 0;
            dp_d     <= '0;
        end else if (load_o) begin
            dp_steps <= 0;
            dp_d     <= d_o;
        end else if (step_en_o) begin
            dp_steps <= dp_steps + 1;
        end
    end
    always_comb begin
        root_i = 16'hBEEF;
        if (dp_steps + int'(step_en_o) == N) root_i = EB'(isqrt(int'(dp_d)));
    end

    // Reference: m_t counts cycles since the accepted start (1 = load, 2..N+1 = steps, N+2 = done)
    bit            m_busy = 0;
    int            m_t    = 0;
    logic [EB-1:0] m_d    = '0;
    logic [EB-1:0] m_raiz = '0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_t = 0; m_d = '0; m_raiz = '0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_t = 1; m_d = operand;
            end
        end else begin
`ifdef SQRT_ABORT_EN
            if (abort && m_t <= N + 1) begin
                m_busy = 0; m_t = 0;
            end else
`endif
            if (m_t == N + 1) begin
                m_t = N + 2; m_raiz = EB'(isqrt(int'(m_d)));
            end else if (m_t == N + 2) begin
                m_busy = 0; m_t = 0;
            end else begin
                m_t++;
            end
        end
    end

    // Per-cycle comparison of every output against the reference
    always @(negedge clk) begin
        check("busy",    busy,      m_busy);
        check("load_o",  load_o,    m_busy && m_t == 1);
        check("step_en", step_en_o, m_busy && m_t >= 2 && m_t <= N + 1);
        check("done",    done,      m_busy && m_t == N + 2);
        check("d_o",     d_o,       m_d);
        check("Raiz",    Raiz,      m_raiz);
        if (m_busy && m_t >= 1 && m_t <= N + 1)
            check("iter_o", iter_o, (m_t == 1) ? N - 1 : N + 1 - m_t);
    end

    task automatic run_op(input logic [EB-1:0] op, input int exp_raiz);
        int cyc = 0, loads = 0, steps = 0;
        bit got = 0;
        @(negedge clk);
        start = 1'b1; operand = op;
        while (!got && cyc < 30) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (load_o) loads++;
            if (step_en_o) steps++;
            if (done) got = 1;
        end
        check("done_seen", got, 1);
        check("latency", cyc, N + 2);
        check("load_cycles", loads, 1);
        check("step_cycles", steps, N);
        check("raiz_result", Raiz, exp_raiz);
    endtask

    task automatic wait_done(input string nm);
        int cyc = 0;
        while (!done && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check(nm, done, 1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; operand = '0;
        #45;
        check("rst_busy", busy, 0);
        check("rst_outs", {load_o, step_en_o, done, iter_o}, 0);
        check("rst_raiz", Raiz, 0);
        #5;
        @(negedge clk);
        reset = 1'b1;

        run_op(16'd127, 11);
        run_op(16'd0, 0);
        run_op(16'd65535, 255);

        // back-to-back with start held high
        @(negedge clk);
        start = 1'b1; operand = 16'd16;
        @(negedge clk);
        wait_done("b2b_done1");
        check("b2b_raiz1", Raiz, 4);
        operand = 16'd15;
        begin
            int gap = 0;
            while (!load_o && gap < 10) begin
                @(negedge clk);
                gap++;
            end
            check("b2b_reload_gap", gap, 2);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_done2");
        check("b2b_raiz2", Raiz, 3);

        // start during ITER must be ignored
        @(negedge clk);
        start = 1'b1; operand = 16'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; operand = 16'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_done");
        check("ign_raiz", Raiz, 14);

        // asynchronous reset while iterating
        @(negedge clk);
        start = 1'b1; operand = 16'd1000;
        @(negedge clk);
        start = 1'b0;
        begin
            int cyc = 0;
            while (!(step_en_o && iter_o == 3'd3) && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            check("reach_iter3", iter_o, 3);
        end
        #2 reset = 1'b0;
        #1;
        check("arst_strobes", {load_o, step_en_o, done, busy}, 0);
        check("arst_iter", iter_o, 0);
        check("arst_d", d_o, 0);
        check("arst_raiz", Raiz, 0);
        @(negedge clk);
        reset = 1'b1;
        run_op(16'd100, 10);

`ifdef SQRT_ABORT_EN
        run_op(16'd127, 11);
        @(negedge clk);
        start = 1'b1; operand = 16'd50;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_step", step_en_o, 0);
        begin
            bit seen = 0;
            repeat (12) begin
                @(negedge clk);
                if (done) seen = 1;
            end
            check("abort_no_done", seen, 0);
        end
        check("abort_raiz", Raiz, 11);
`endif

        // randomized operands
        for (int i = 0; i < 20; i++) begin
            logic [EB-1:0] r;
            r = EB'($urandom);
            run_op(r, isqrt(int'(r)));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
